// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: turns one line refill or write-back request
// into a single 8-beat INCR burst and reports completion to the core.
module axi_line_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        i_start_read,
  input  logic                        i_start_write,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  logic [LINE_WIDTH-1:0]       i_data_write,
  output logic [LINE_WIDTH-1:0]       o_data_read,
  output logic                        o_read_last,
  output logic                        o_b_resp,
  output logic                        o_error,
  output logic [ADDR_WIDTH-1:0]       o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wlast,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  input  logic [1:0]                  i_bresp,
  input  logic                        i_bvalid,
  output logic                        o_bready,
  output logic [ADDR_WIDTH-1:0]       o_araddr,
  output logic [7:0]                  o_arlen,
  output logic [2:0]                  o_arsize,
  output logic [1:0]                  o_arburst,
  output logic                        o_arvalid,
  input  logic                        i_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]                  i_rresp,
  input  logic                        i_rlast,
  input  logic                        i_rvalid,
  output logic                        o_rready
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(63);

  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wbuf_q, wbuf_d;
  logic [LINE_WIDTH-1:0]   rline_q, rline_d;
  logic [CNT_W-1:0]        w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0]        r_cnt_q, r_cnt_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    err_q, err_d;
  logic                    kind_rd_q, kind_rd_d;
  logic                    aw_hs, w_hs, r_hs;

  // Constant burst attributes and state-decoded handshake signals
  assign o_awaddr    = addr_q;
  assign o_araddr    = addr_q;
  assign o_awlen     = 8'(BEATS - 1);
  assign o_arlen     = 8'(BEATS - 1);
  assign o_awsize    = 3'd3;
  assign o_arsize    = 3'd3;
  assign o_awburst   = 2'b01;
  assign o_arburst   = 2'b01;
  assign o_wstrb     = '1;
  assign o_awvalid   = (state_q == WRITE) && !aw_done_q;
  assign o_wvalid    = (state_q == WRITE) && !w_done_q;
  assign o_wlast     = (w_cnt_q == LAST_BEAT);
  assign o_bready    = (state_q == WR_RESP);
  assign o_arvalid   = (state_q == RD_ADDR);
  assign o_rready    = (state_q == RD_DATA);
  assign o_read_last = (state_q == DONE) && kind_rd_q;
  assign o_b_resp    = (state_q == DONE) && !kind_rd_q;
  assign o_error     = (state_q == DONE) && err_q;
  assign o_data_read = rline_q;
  assign aw_hs       = o_awvalid && i_awready;
  assign w_hs        = o_wvalid && i_wready;
  assign r_hs        = o_rready && i_rvalid;

  // Select the write-buffer beat addressed by the W counter
  always_comb begin
    o_wdata = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (w_cnt_q == CNT_W'(k)) o_wdata = wbuf_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  end

  // Next-state, capture and counter logic for the burst sequencer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    rline_d   = rline_q;
    w_cnt_d   = w_cnt_q;
    r_cnt_d   = r_cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    kind_rd_d = kind_rd_q;
    unique case (state_q)
      IDLE: begin
        if (i_start_write) begin
          addr_d  = i_addr & ADDR_MASK;
          wbuf_d  = i_data_write;
          state_d = WRITE;
        end else if (i_start_read) begin
          addr_d  = i_addr & ADDR_MASK;
          state_d = RD_ADDR;
        end
      end
      WRITE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) begin
          w_cnt_d = w_cnt_q + 1'b1;
          if (w_cnt_q == LAST_BEAT) w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_cnt_q == LAST_BEAT))) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_bvalid) begin
          if (i_bresp != 2'b00) err_d = 1'b1;
          kind_rd_d = 1'b0;
          state_d   = DONE;
        end
      end
      RD_ADDR: begin
        if (i_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          for (int k = 0; k < BEATS; k++) begin
            if (r_cnt_q == CNT_W'(k)) rline_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_rdata;
          end
          if ((i_rresp != 2'b00) || (i_rlast != (r_cnt_q == LAST_BEAT))) err_d = 1'b1;
          r_cnt_d = r_cnt_q + 1'b1;
          if (r_cnt_q == LAST_BEAT) begin
            kind_rd_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        err_d     = 1'b0;
        w_cnt_d   = '0;
        r_cnt_d   = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wbuf_q    <= '0;
      rline_q   <= '0;
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      kind_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      rline_q   <= rline_d;
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      kind_rd_q <= kind_rd_d;
    end
  end

endmodule
